lfsr_rng: RTL and testbench

- Parametrised pseudo-random source for game logic: events, moods, hunger jitter.
- The LFSR free-runs every clock, so the user's request timing adds entropy.
- Samples are drawn on request with a req/valid handshake. An optional bound gives uniform values in [0, bound-1] by mask-and-reject sampling.
- Supports runtime reseed, all-zero lockup recovery and a bounded retry count, so latency is deterministic.

---
 rtl/lfsr_rng.sv | 130 +++++++++++++
 tb/tb_lfsr_rng.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Free-running Fibonacci LFSR with a req/valid sampler that returns uniform values
// below an optional bound using mask-and-reject with a bounded number of attempts.
module lfsr_rng #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
    parameter int unsigned      STEPS      = 8,
    parameter int unsigned      MAX_TRY    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    input  logic [WIDTH-1:0] bound,
    output logic             busy,
    output logic             rand_valid,
    output logic [WIDTH-1:0] rand_out,
    output logic             lockup,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int unsigned CNT_W = $clog2(STEPS + 1);
    localparam int unsigned TRY_W = $clog2(MAX_TRY + 1);

    typedef enum logic {IDLE, GEN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TRY_W-1:0] try_q, try_d;
    logic [WIDTH-1:0] bound_q, bound_d;
    logic             busy_d, valid_d;
    logic [WIDTH-1:0] out_d;

    logic             fb;
    logic [WIDTH-1:0] shift_nxt, lfsr_nxt;
    logic             lock_nxt;
    logic [WIDTH-1:0] bound_m1, mask, v;
    logic             in_range;

    // Next LFSR value: seed load wins, then all-zero recovery
    always_comb begin
        fb        = ^(lfsr_state & TAPS);
        shift_nxt = {lfsr_state[WIDTH-2:0], fb};
        lfsr_nxt  = shift_nxt;
        lock_nxt  = 1'b0;
        if (seed_load) begin
            lfsr_nxt = (seed == '0) ? RESET_SEED : seed;
        end else if (shift_nxt == '0) begin
            lfsr_nxt = RESET_SEED;
            lock_nxt = 1'b1;
        end
    end

    // Leading-one fill of bound-1; bound==0 wraps to all ones, bound==1 gives zero
    always_comb begin
        bound_m1 = bound_q - WIDTH'(1);
        mask     = bound_m1;
        for (int i = 1; i < WIDTH; i++) begin
            mask = mask | (mask >> i);
        end
        v        = lfsr_state & mask;
        in_range = (bound_q == '0) || (v < bound_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        try_d   = try_q;
        bound_d = bound_q;
        busy_d  = busy;
        valid_d = 1'b0;
        out_d   = rand_out;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = GEN;
                    bound_d = bound;
                    cnt_d   = CNT_W'(STEPS);
                    try_d   = TRY_W'(1);
                    busy_d  = 1'b1;
                end
            end
            GEN: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (in_range || (try_q >= TRY_W'(MAX_TRY))) begin
                        // v < 2*bound here, so one subtraction lands the fallback in range
                        out_d   = in_range ? v : (v - bound_q);
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                        cnt_d   = '0;
                        try_d   = '0;
                    end else begin
                        try_d = try_q + TRY_W'(1);
                        cnt_d = CNT_W'(STEPS);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            try_q      <= '0;
            bound_q    <= '0;
            busy       <= 1'b0;
            rand_valid <= 1'b0;
            rand_out   <= '0;
            lfsr_state <= RESET_SEED;
            lockup     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            try_q      <= try_d;
            bound_q    <= bound_d;
            busy       <= busy_d;
            rand_valid <= valid_d;
            rand_out   <= out_d;
            lfsr_state <= lfsr_nxt;
            lockup     <= lock_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// Scoreboard bench for lfsr_rng: three instances (default, MAX_TRY=1, TAPS=8'h38)
// checked against an arithmetic reference of the LFSR sequence and sampling rules.
module tb_lfsr_rng;

    localparam int STEPS = 8;
    localparam int ND    = 3;

    typedef struct {
        logic [7:0] val;
        logic [7:0] bnd;
        int         done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seed_load;
    logic [7:0] seed;
    logic       req;
    logic [7:0] bound;
    logic       req_off = 1'b0;

    logic [ND-1:0] busy, rand_valid, lockup;
    logic [7:0]    rand_out   [ND];
    logic [7:0]    lfsr_state [ND];

    always #5 clk = ~clk;

    lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .RESET_SEED(8'h01), .STEPS(STEPS), .MAX_TRY(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .req(req), .bound(bound),
        .busy(busy[0]), .rand_valid(rand_valid[0]), .rand_out(rand_out[0]),
        .lockup(lockup[0]), .lfsr_state(lfsr_state[0]));

    lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .RESET_SEED(8'h01), .STEPS(STEPS), .MAX_TRY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .req(req), .bound(bound),
        .busy(busy[1]), .rand_valid(rand_valid[1]), .rand_out(rand_out[1]),
        .lockup(lockup[1]), .lfsr_state(lfsr_state[1]));

    lfsr_rng #(.WIDTH(8), .TAPS(8'h38), .RESET_SEED(8'h01), .STEPS(STEPS), .MAX_TRY(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .req(req_off), .bound(bound),
        .busy(busy[2]), .rand_valid(rand_valid[2]), .rand_out(rand_out[2]),
        .lockup(lockup[2]), .lfsr_state(lfsr_state[2]));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int req_v);
        n_total++;
        if (act == req_v) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, req_v, req_v, $time);
    endtask

    // Reference step: doubling mod 256 plus parity of tapped bits; zero becomes 1
    function automatic logic [7:0] step8(input logic [7:0] s, input logic [7:0] taps);
        int ones = 0;
        int x;
        for (int i = 0; i < 8; i++) if (s[i] && taps[i]) ones++;
        x = (int'(s) * 2) % 256 + (ones % 2);
        if (x == 0) x = 1;
        return 8'(x);
    endfunction

    function automatic void predict(input logic [7:0] s0, input logic [7:0] bnd, input int maxtry,
                                    output logic [7:0] val, output int lat);
        logic [7:0] s = s0;
        int m = 255;
        int v = 0;
        if (bnd != 0) begin
            m = 0;
            while (m < int'(bnd) - 1) m = m * 2 + 1;
        end
        for (int n = 1; n <= maxtry; n++) begin
            for (int k = 0; k < STEPS; k++) s = step8(s, 8'hB8);
            v = int'(s) & m;
            if (bnd == 0 || v < int'(bnd)) begin
                val = 8'(v);
                lat = n * STEPS;
                return;
            end
        end
        val = 8'(v - int'(bnd));
        lat = maxtry * STEPS;
    endfunction

    int         cyc = 0;
    logic [7:0] m_state [ND] = '{8'h01, 8'h01, 8'h01};
    logic       m_lock  [ND] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] m_taps  [ND] = '{8'hB8, 8'hB8, 8'h38};
    int         m_maxt  [2]  = '{4, 1};
    bit         m_act   [2]  = '{1'b0, 1'b0};
    int         m_done  [2]  = '{0, 0};
    int         m_acc   [2]  = '{0, 0};
    int         m_deliv [2]  = '{0, 0};
    int         n_valid [2]  = '{0, 0};
    exp_t       q0[$];
    exp_t       q1[$];

    // Reference model: advances at each edge from the bench-driven inputs
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                m_state[d] = 8'h01;
                m_lock[d]  = 1'b0;
            end
            for (int d = 0; d < 2; d++) m_act[d] = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (m_act[d] && cyc == m_done[d]) m_deliv[d]++;
                if (req && (!m_act[d] || cyc > m_done[d])) begin
                    exp_t e;
                    int   lat;
                    predict(m_state[d], bound, m_maxt[d], e.val, lat);
                    e.bnd     = bound;
                    e.done    = cyc + lat;
                    m_act[d]  = 1'b1;
                    m_done[d] = e.done;
                    m_acc[d]++;
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
            for (int d = 0; d < ND; d++) begin
                logic [7:0] nx;
                m_lock[d] = 1'b0;
                if (seed_load) begin
                    nx = (seed == 8'h00) ? 8'h01 : seed;
                end else begin
                    nx = step8(m_state[d], m_taps[d]);
                    if (nx == 8'h01 && m_state[d][6:0] == 7'h00 && ^(m_state[d] & m_taps[d]) == 1'b0)
                        m_lock[d] = 1'b1;
                end
                m_state[d] = nx;
            end
        end
    end

    // Monitor: compares every cycle and pops the scoreboard on each rand_valid
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("lfsr_state[%0d]", d), int'(lfsr_state[d]), int'(m_state[d]));
                chk($sformatf("lockup[%0d]", d), int'(lockup[d]), int'(m_lock[d]));
            end
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy[%0d]", d), int'(busy[d]), int'(m_act[d] && cyc < m_done[d]));
                if (rand_valid[d]) begin
                    int qs;
                    n_valid[d]++;
                    qs = (d == 0) ? q0.size() : q1.size();
                    if (qs == 0) begin
                        chk($sformatf("spurious_valid[%0d]", d), 1, 0);
                    end else begin
                        exp_t e;
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rand_out[%0d]", d), int'(rand_out[d]), int'(e.val));
                        chk($sformatf("valid_cycle[%0d]", d), cyc, e.done);
                        if (e.bnd != 0)
                            chk($sformatf("below_bound[%0d]", d), int'(rand_out[d] < e.bnd), 1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (((m_act[0] && cyc < m_done[0]) || (m_act[1] && cyc < m_done[1])) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    logic [7:0] fr   [8] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    logic [7:0] bset [5] = '{8'd1, 8'd3, 8'd10, 8'd128, 8'd255};

    task automatic directed_req(input logic [7:0] bnd, input int d, input logic [7:0] want, input string nm);
        int t0;
        int n = 0;
        seed      = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 1'b1;
        bound     = bnd;
        tick();
        req = 1'b0;
        t0  = cyc;
        do begin
            @(negedge clk);
            n++;
        end while (!rand_valid[d] && n < 50);
        chk({nm, "_valid_seen"}, int'(rand_valid[d]), 1);
        chk({nm, "_value"}, int'(rand_out[d]), int'(want));
        chk({nm, "_latency"}, cyc - t0, STEPS);
    endtask

    initial begin
        int target;
        int n;
        int nv0;
        rst_n     = 1'b0;
        seed_load = 1'b0;
        seed      = 8'h00;
        req       = 1'b0;
        bound     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_busy", int'(busy[d]), 0);
            chk("rst_valid", int'(rand_valid[d]), 0);
            chk("rst_lockup", int'(lockup[d]), 0);
            chk("rst_rand_out", int'(rand_out[d]), 0);
            chk("rst_lfsr", int'(lfsr_state[d]), 1);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Free-running sequence after loading seed 1
        seed      = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("freerun_%0d", k), int'(lfsr_state[0]), int'(fr[k]));
        end

        wait_idle();
        directed_req(8'd0, 0, 8'h1C, "unbounded");
        wait_idle();
        directed_req(8'd10, 1, 8'h02, "fallback");
        wait_idle();

        // Lockup recovery on the TAPS=8'h38 instance, then zero-seed load
        seed      = 8'h80;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        @(negedge clk);
        chk("lock_seeded", int'(lfsr_state[2]), 8'h80);
        chk("lock_none_on_load", int'(lockup[2]), 0);
        @(posedge clk);
        @(negedge clk);
        chk("lock_recover", int'(lfsr_state[2]), 8'h01);
        chk("lock_pulse", int'(lockup[2]), 1);
        @(posedge clk);
        @(negedge clk);
        chk("lock_pulse_end", int'(lockup[2]), 0);
        seed      = 8'h00;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        @(negedge clk);
        chk("zero_seed_state", int'(lfsr_state[2]), 8'h01);
        chk("zero_seed_nolock", int'(lockup[2]), 0);
        chk("zero_seed_state0", int'(lfsr_state[0]), 8'h01);

        // Randomised back-to-back sweep; requests while busy must be dropped
        target = m_acc[0] + 1000;
        n      = 0;
        while (m_acc[0] < target && n < 60000) begin
            req   = ($urandom_range(0, 3) != 0);
            bound = bset[$urandom_range(0, 4)];
            tick();
            n++;
        end
        req = 1'b0;
        chk("sweep_completed", int'(m_acc[0] >= target), 1);
        wait_idle();

        // Reset in the middle of a request aborts it silently
        nv0   = n_valid[0];
        req   = 1'b1;
        bound = 8'd255;
        tick();
        req = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_valid", int'(rand_valid[0]), 0);
        chk("abort_lfsr", int'(lfsr_state[0]), 1);
        chk("abort_rand_out", int'(rand_out[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_valid", n_valid[0] - nv0, 0);

        for (int d = 0; d < 2; d++) chk($sformatf("valid_count[%0d]", d), n_valid[d], m_deliv[d]);
        chk("queue0_empty", q0.size(), 0);
        chk("queue1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
